shared_reg_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit storage register (a bank of D flip-flops) among N_REQ requesters.
- Each cycle it picks at most one requester and captures that requester's data into the register.
- It reports the winner with a one-hot grant and a valid pulse.
- An optional lock lets the current winner keep the register for back-to-back writes, bounded by MAX_HOLD.

---
 rtl/shared_reg_arbiter_pkg.sv | 25 ++
 rtl/shared_reg_arbiter_rr_pick.sv | 30 +++
 rtl/shared_reg_arbiter.sv | 130 +++++++++++++
 tb/tb_shared_reg_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Parameter-dependent widths are derived with the helper functions below.
package shared_reg_arbiter_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot vector with bit idx set; callers truncate to their own width.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational rotating-priority finder: first set req bit at or after ptr,
// wrapping modulo N_REQ.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found_c,
  output logic [IDX_W-1:0] winner_c
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    int idx;
    idx      = 0;
    found_c  = 1'b0;
    winner_c = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % int'(N_REQ);
      if (req[idx]) begin
        found_c  = 1'b1;
        winner_c = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters,
// with an optional lock letting the winner keep ownership for up to MAX_HOLD writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ*WIDTH-1:0]      wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  output logic [idx_width(N_REQ)-1:0] owner_id,
  output logic                        busy
);

  localparam int unsigned IDX_W  = idx_width(N_REQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic               q_valid_nxt;
  logic [IDX_W-1:0]   owner_nxt;
  logic               busy_nxt;

  logic               found_c;
  logic [IDX_W-1:0]   winner_c;

  shared_reg_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .found_c  (found_c),
    .winner_c (winner_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      q        <= '0;
      gnt      <= '0;
      q_valid  <= 1'b0;
      owner_id <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      q        <= q_nxt;
      gnt      <= gnt_nxt;
      q_valid  <= q_valid_nxt;
      owner_id <= owner_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state: continue a locked burst, or release and arbitrate in the same cycle.
  always_comb begin
    logic             do_arb;
    logic             keep;
    logic [IDX_W-1:0] w;

    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    q_nxt       = q;
    gnt_nxt     = '0;
    q_valid_nxt = 1'b0;
    owner_nxt   = owner_id;
    busy_nxt    = busy;
    do_arb      = 1'b0;
    keep        = 1'b0;
    w           = winner_c;

    case (state)
      IDLE: begin
        do_arb = 1'b1;
      end
      OWNED: begin
        keep = req[owner_id] && lock[owner_id] && (hold_cnt < HOLD_W'(MAX_HOLD));
        if (keep) begin
          q_nxt       = wdata[int'(owner_id) * int'(WIDTH) +: WIDTH];
          gnt_nxt     = N_REQ'(onehot(int'(owner_id)));
          q_valid_nxt = 1'b1;
          hold_nxt    = hold_cnt + HOLD_W'(1);
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          hold_nxt  = '0;
          do_arb    = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    if (do_arb && found_c) begin
      q_nxt       = wdata[int'(w) * int'(WIDTH) +: WIDTH];
      gnt_nxt     = N_REQ'(onehot(int'(w)));
      q_valid_nxt = 1'b1;
      owner_nxt   = w;
      ptr_nxt     = (w == IDX_W'(N_REQ - 1)) ? '0 : w + IDX_W'(1);
      if (lock[w]) begin
        state_nxt = OWNED;
        hold_nxt  = HOLD_W'(1);
        busy_nxt  = 1'b1;
      end else begin
        state_nxt = IDLE;
        hold_nxt  = '0;
        busy_nxt  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
module tb_shared_reg_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [1:0]             owner_id;
  logic                   busy;

  int vectors;
  int miscompares;

  shared_reg_arbiter #(
    .N_REQ    (4),
    .WIDTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .q_valid  (q_valid),
    .owner_id (owner_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle: {gnt, q, q_valid, busy, owner_id}
  function automatic logic [15:0] obs();
    return {gnt, q, q_valid, busy, owner_id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = base + 8'(i);
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1; req = '0; lock = '0; set_data(8'h10);
    tick();
    tick();
    exp = {4'b0000, 8'h00, 1'b0, 1'b0, 2'd0};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL reset: got {gnt,q,qv,busy,own}=%h expected %h", obs(), exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [15:0] exp;
    req = 4'b1111; lock = '0; set_data(8'h10);
    for (int k = 0; k < 8; k++) begin
      tick();
      exp = {4'(1 << (k % 4)), 8'h10 + 8'(k % 4), 1'b1, 1'b0, 2'(k % 4)};
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: got %h expected %h", k, obs(), exp);
      end
    end
    req = '0;
  endtask

  // ptr is 0 here; single write from requester 2, then idle cycles hold q.
  task automatic test_single_idle();
    logic [15:0] exp;
    req = 4'b0100; lock = '0; set_data(8'h00); wdata[2*8 +: 8] = 8'hA5;
    tick();
    exp = {4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL single: got %h expected %h", obs(), exp);
    end
    req = '0; set_data(8'h77);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp = {4'b0000, 8'hA5, 1'b0, 1'b0, 2'd2};
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL idle[%0d]: got %h expected %h", k, obs(), exp);
      end
    end
  endtask

  // ptr is 3 after the single write from requester 2.
  task automatic test_pointer_wrap();
    logic [15:0] exp;
    req = 4'b1001; lock = '0; set_data(8'h20);
    tick();
    exp = {4'b1000, 8'h23, 1'b1, 1'b0, 2'd3};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL wrap_first: got %h expected %h", obs(), exp);
    end
    tick();
    exp = {4'b0001, 8'h20, 1'b1, 1'b0, 2'd0};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL wrap_second: got %h expected %h", obs(), exp);
    end
    req = '0;
  endtask

  task automatic test_lock_max_hold();
    logic [15:0] exp;
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0; req = 4'b0011; lock = 4'b0001; set_data(8'h30);
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = {4'b0001, 8'h30, 1'b1, 1'b1, 2'd0};
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL hold[%0d]: got %h expected %h", k, obs(), exp);
      end
    end
    tick();
    exp = {4'b0010, 8'h31, 1'b1, 1'b0, 2'd1};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL hold_release: got %h expected %h", obs(), exp);
    end
    req = '0; lock = '0;
  endtask

  task automatic test_voluntary_release();
    logic [15:0] exp;
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0; req = 4'b0011; lock = 4'b0001; set_data(8'h40);
    for (int k = 0; k < 2; k++) begin
      tick();
      exp = {4'b0001, 8'h40, 1'b1, 1'b1, 2'd0};
      vectors++;
      if (obs() !== exp) begin
        miscompares++;
        $display("FAIL vol_locked[%0d]: got %h expected %h", k, obs(), exp);
      end
    end
    lock = '0;
    tick();
    exp = {4'b0010, 8'h41, 1'b1, 1'b0, 2'd1};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL vol_release: got %h expected %h", obs(), exp);
    end
    tick();
    exp = {4'b0001, 8'h40, 1'b1, 1'b0, 2'd0};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL vol_after: got %h expected %h", obs(), exp);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] exp;
    rst = 1'b1; req = '0; lock = '0;
    tick();
    rst = 1'b0; req = 4'b0100; lock = 4'b0100; set_data(8'h50);
    tick();
    tick();
    exp = {4'b0100, 8'h52, 1'b1, 1'b1, 2'd2};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL burst_pre: got %h expected %h", obs(), exp);
    end
    rst = 1'b1;
    tick();
    exp = {4'b0000, 8'h00, 1'b0, 1'b0, 2'd0};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL burst_reset: got %h expected %h", obs(), exp);
    end
    rst = 1'b0; req = 4'b1111; lock = '0; set_data(8'h60);
    tick();
    exp = {4'b0001, 8'h60, 1'b1, 1'b0, 2'd0};
    vectors++;
    if (obs() !== exp) begin
      miscompares++;
      $display("FAIL burst_post: got %h expected %h", obs(), exp);
    end
    req = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    req   = '0;
    lock  = '0;
    wdata = '0;
    test_reset();
    test_round_robin();
    test_single_idle();
    test_pointer_wrap();
    test_lock_max_hold();
    test_voluntary_release();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
